// File: rtl/isa_pkg.sv
// Shared definitions for the fetch side: LUT index width, PC width, FSM states.
package isa_pkg;

  localparam int LUT_AW = 5;
  localparam int PC_W   = 12;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/sat_counter.sv
// Unsigned up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;

  // Clear on reset or on a new run; count up while enabled until saturated.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      count_q <= '0;
    end else if (en && (count_q != {W{1'b1}})) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Program-counter sequencer: steps, branches through the target LUT, stalls,
// halts, and stops with an overflow flag when it would run past the top PC.
module pc_fetch_ctrl
  import isa_pkg::*;
#(
  parameter int          D        = PC_W,
  parameter int unsigned START_PC = 0,
  parameter int          CW       = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stall,
  input  logic              halt,
  input  logic              branch_en,
  input  logic [LUT_AW-1:0] branch_idx,
  input  logic [D-1:0]      lut_target,
  output logic [LUT_AW-1:0] lut_addr,
  output logic [D-1:0]      pc,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic [CW-1:0]     cycles
);

  localparam logic [D-1:0] START_VAL = D'(START_PC);
  localparam logic [D-1:0] PC_LAST   = {D{1'b1}};

  fetch_state_t state_q, state_d;
  logic [D-1:0] pc_q, pc_d;
  logic         overflow_q, overflow_d;
  logic         run_w;
  logic         launch_w;

  assign run_w    = (state_q == RUN);
  // A run launches from IDLE or DONE; start is ignored while running.
  assign launch_w = start && !run_w;

  // Next-state / next-pc priority chain: halt, stall, branch, fall-off, step.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    overflow_d = overflow_q;
    case (state_q)
      RUN: begin
        if (halt) begin
          state_d = DONE;
        end else if (stall) begin
          pc_d = pc_q;
        end else if (branch_en && (branch_idx != '0)) begin
          pc_d = lut_target;
        end else if (pc_q == PC_LAST) begin
          state_d    = DONE;
          overflow_d = 1'b1;
        end else begin
          pc_d = pc_q + 1'b1;
        end
      end
      default: begin
        if (launch_w) begin
          state_d    = RUN;
          pc_d       = START_VAL;
          overflow_d = 1'b0;
        end
      end
    endcase
  end

  // State, pc and overflow registers; reset overrides everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      pc_q       <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      overflow_q <= overflow_d;
    end
  end

  // Cycles spent in RUN, including the edge that leaves RUN.
  sat_counter #(.W(CW)) u_cycles (
    .clk   (clk),
    .reset (reset),
    .clr   (launch_w),
    .en    (run_w),
    .count (cycles)
  );

  // The LUT is only addressed by a live branch; otherwise index 0.
  assign lut_addr = (run_w && branch_en) ? branch_idx : '0;

  assign pc       = pc_q;
  assign busy     = run_w;
  assign done     = (state_q == DONE);
  assign overflow = overflow_q;

endmodule
